// File: rtl/sim_pkg.sv
// +--------------------------------------------------------------------------+
// | sim_pkg : shared types, FP32 constants and NaN helper                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package sim_pkg;

   localparam logic [31:0] FP32_QNAN     = 32'h7FC0_0000;
   localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP32_NEG_ZERO = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   function automatic logic fp32_is_nan(input logic [31:0] v);
      return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_gt.sv
// +--------------------------------------------------------------------------+
// | fp32_gt : combinational FP32 strict greater-than (a > b), -0 == +0       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp32_gt
   import sim_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        gt
);

   logic [31:0] w_a_canon;
   logic [31:0] w_b_canon;
   logic [31:0] w_key_a;
   logic [31:0] w_key_b;

   assign w_a_canon = (a == FP32_NEG_ZERO) ? FP32_POS_ZERO : a;
   assign w_b_canon = (b == FP32_NEG_ZERO) ? FP32_POS_ZERO : b;

   // Sign-magnitude to monotonic unsigned key.
   assign w_key_a = w_a_canon[31] ? ~w_a_canon : (w_a_canon ^ 32'h8000_0000);
   assign w_key_b = w_b_canon[31] ? ~w_b_canon : (w_b_canon ^ 32'h8000_0000);

   assign gt = (w_key_a > w_key_b);

endmodule

`default_nettype wire

// File: rtl/sim_best_match.sv
// +--------------------------------------------------------------------------+
// | sim_best_match : arg-max of N_CAND FP32 similarities, valid/ready result |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sim_best_match
   import sim_pkg::*;
#(
   parameter int N_CAND = 8,
   parameter int IDX_W  = $clog2(N_CAND)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [31:0]      sim_in,
   input  logic             sim_valid,
   output logic [IDX_W-1:0] best_idx,
   output logic [31:0]      best_score,
   output logic             result_valid,
   input  logic             result_ready,
   output logic             busy,
   output logic             nan_seen,
   output logic             overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      best_q, best_d;
   logic             have_q, have_d;
   logic             nan_q, nan_d;
   logic             rv_q, rv_d;
   logic             ovr_q, ovr_d;

   logic             w_gt;
   logic             w_in_nan;
   logic             w_start;

   fp32_gt u_gt (
      .a  (sim_in),
      .b  (best_q),
      .gt (w_gt)
   );

   assign w_in_nan = fp32_is_nan(sim_in);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      best_d  = best_q;
      have_d  = have_q;
      nan_d   = nan_q;
      rv_d    = rv_q;
      ovr_d   = ovr_q;
      w_start = 1'b0;

      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
         have_d  = 1'b0;
         nan_d   = 1'b0;
         rv_d    = 1'b0;
         ovr_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               w_start = sim_valid;
            end
            COLLECT: begin
               if (sim_valid) begin
                  if (w_in_nan) begin
                     nan_d = 1'b1;
                  end else if (!have_q || w_gt) begin
                     best_d = sim_in;
                     idx_d  = cnt_q;
                     have_d = 1'b1;
                  end
                  if (cnt_q == LAST_IDX) begin
                     state_d = HOLD;
                     rv_d    = 1'b1;
                  end else begin
                     cnt_d = cnt_q + IDX_W'(1);
                  end
               end
            end
            HOLD: begin
               if (result_ready) begin
                  state_d = IDLE;
                  rv_d    = 1'b0;
                  cnt_d   = '0;
                  w_start = sim_valid;
               end else if (sim_valid) begin
                  ovr_d = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase

         // First sample of a batch is loaded unconditionally; a NaN parks the
         // default quiet-NaN value so an all-NaN batch reports it at index 0.
         if (w_start) begin
            state_d = COLLECT;
            cnt_d   = IDX_W'(1);
            idx_d   = '0;
            nan_d   = w_in_nan;
            have_d  = !w_in_nan;
            best_d  = w_in_nan ? FP32_QNAN : sim_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         best_q  <= '0;
         have_q  <= 1'b0;
         nan_q   <= 1'b0;
         rv_q    <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         best_q  <= best_d;
         have_q  <= have_d;
         nan_q   <= nan_d;
         rv_q    <= rv_d;
         ovr_q   <= ovr_d;
      end
   end

   assign best_idx     = idx_q;
   assign best_score   = best_q;
   assign result_valid = rv_q;
   assign busy         = (state_q == COLLECT);
   assign nan_seen     = nan_q;
   assign overrun      = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_sim_best_match.sv
// +--------------------------------------------------------------------------+
// | tb_sim_best_match : directed self-checking bench, N_CAND = 4             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sim_best_match;

   localparam int N_CAND = 4;
   localparam int IDX_W  = 2;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic [31:0]      sim_in;
   logic             sim_valid;
   logic [IDX_W-1:0] best_idx;
   logic [31:0]      best_score;
   logic             result_valid;
   logic             result_ready;
   logic             busy;
   logic             nan_seen;
   logic             overrun;

   int n_vec;
   int n_err;

   sim_best_match #(.N_CAND(N_CAND), .IDX_W(IDX_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .sim_in       (sim_in),
      .sim_valid    (sim_valid),
      .best_idx     (best_idx),
      .best_score   (best_score),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy),
      .nan_seen     (nan_seen),
      .overrun      (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the capturing edge.
   task automatic send(input logic [31:0] v);
      sim_valid = 1'b1;
      sim_in    = v;
      @(negedge clk);
      sim_valid = 1'b0;
      sim_in    = '0;
   endtask

   task automatic handshake();
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("hs_rv_low", {31'd0, result_valid}, 32'd0);
   endtask

   task automatic check_result(input string tag, input logic [1:0] idx,
                               input logic [31:0] score, input logic nan);
      check({tag, "_rv"},    {31'd0, result_valid}, 32'd1);
      check({tag, "_idx"},   {30'd0, best_idx},     {30'd0, idx});
      check({tag, "_score"}, best_score,            score);
      check({tag, "_nan"},   {31'd0, nan_seen},     {31'd0, nan});
      check({tag, "_busy"},  {31'd0, busy},         32'd0);
   endtask

   initial begin
      n_vec        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      clear        = 1'b0;
      sim_in       = '0;
      sim_valid    = 1'b0;
      result_ready = 1'b0;
      repeat (2) @(negedge clk);

      check("rst_rv",    {31'd0, result_valid}, 32'd0);
      check("rst_idx",   {30'd0, best_idx},     32'd0);
      check("rst_score", best_score,            32'd0);
      check("rst_busy",  {31'd0, busy},         32'd0);
      check("rst_nan",   {31'd0, nan_seen},     32'd0);
      check("rst_ovr",   {31'd0, overrun},      32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic positive batch, latency check after 3rd and 4th samples
      send(32'h3F00_0000);
      check("b1_busy", {31'd0, busy}, 32'd1);
      send(32'h3F80_0000);
      send(32'h3E80_0000);
      check("b1_rv_early", {31'd0, result_valid}, 32'd0);
      send(32'h3F40_0000);
      check_result("b1", 2'd1, 32'h3F80_0000, 1'b0);
      handshake();

      // Negative values and the signed-zero tie
      send(32'hBF00_0000);
      send(32'h8000_0000);
      send(32'h0000_0000);
      send(32'hBF80_0000);
      check_result("b2", 2'd1, 32'h8000_0000, 1'b0);
      handshake();

      // NaNs interleaved with a tie
      send(32'h7FC0_0000);
      send(32'h3F00_0000);
      send(32'h7F80_0001);
      send(32'h3F00_0000);
      check_result("b3", 2'd1, 32'h3F00_0000, 1'b1);
      handshake();

      // All-NaN batch
      send(32'h7FC0_0000);
      send(32'h7F80_0001);
      send(32'hFFC0_0000);
      send(32'h7FFF_FFFF);
      check_result("b4", 2'd0, 32'h7FC0_0000, 1'b1);
      handshake();

      // Infinities and extreme finite values
      send(32'hFF80_0000);
      send(32'h7F80_0000);
      send(32'h0000_0001);
      send(32'h7F7F_FFFF);
      check_result("b5", 2'd1, 32'h7F80_0000, 1'b0);
      handshake();

      // Stall in HOLD with two dropped samples
      send(32'h3E80_0000);
      send(32'h3F40_0000);
      send(32'h3F00_0000);
      send(32'h3E00_0000);
      check_result("b6", 2'd1, 32'h3F40_0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         sim_valid = (i == 1) || (i == 3);
         sim_in    = 32'h7F80_0000;
         @(negedge clk);
         sim_valid = 1'b0;
         check("hold_rv",    {31'd0, result_valid}, 32'd1);
         check("hold_idx",   {30'd0, best_idx},     32'd1);
         check("hold_score", best_score,            32'h3F40_0000);
      end
      check("hold_ovr", {31'd0, overrun}, 32'd1);

      // Handshake coincident with the next batch's first sample
      result_ready = 1'b1;
      sim_valid    = 1'b1;
      sim_in       = 32'h3F80_0000;
      @(negedge clk);
      result_ready = 1'b0;
      sim_valid    = 1'b0;
      check("b7_rv0",    {31'd0, result_valid}, 32'd0);
      check("b7_busy",   {31'd0, busy},         32'd1);
      check("b7_score0", best_score,            32'h3F80_0000);
      check("b7_ovr",    {31'd0, overrun},      32'd1);
      send(32'h3E80_0000);
      send(32'h3E80_0000);
      check("b7_rv_early", {31'd0, result_valid}, 32'd0);
      send(32'h3E80_0000);
      check_result("b7", 2'd0, 32'h3F80_0000, 1'b0);
      handshake();

      // Clear mid-batch with a coincident sample
      send(32'h3F80_0000);
      send(32'h3F80_0000);
      clear     = 1'b1;
      sim_valid = 1'b1;
      sim_in    = 32'h7F80_0000;
      @(negedge clk);
      clear     = 1'b0;
      sim_valid = 1'b0;
      check("clr_rv",   {31'd0, result_valid}, 32'd0);
      check("clr_busy", {31'd0, busy},         32'd0);
      check("clr_ovr",  {31'd0, overrun},      32'd0);
      send(32'h3E80_0000);
      send(32'h3E80_0000);
      send(32'h3E80_0000);
      check("clr_rv_early", {31'd0, result_valid}, 32'd0);
      send(32'h3E80_0000);
      check_result("b8", 2'd0, 32'h3E80_0000, 1'b0);
      handshake();

      // Asynchronous reset between clock edges
      send(32'h7FC0_0000);
      send(32'h3F80_0000);
      #2 rst_n = 1'b0;
      #1;
      check("arst_rv",    {31'd0, result_valid}, 32'd0);
      check("arst_busy",  {31'd0, busy},         32'd0);
      check("arst_score", best_score,            32'd0);
      check("arst_idx",   {30'd0, best_idx},     32'd0);
      check("arst_nan",   {31'd0, nan_seen},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(32'h3E00_0000);
      send(32'h3E80_0000);
      send(32'h3F00_0000);
      send(32'h3E80_0000);
      check_result("b9", 2'd2, 32'h3F00_0000, 1'b0);
      handshake();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
